// File: rtl/l1_bus_merger.sv
// l1_bus_merger: N-to-1 merger for one coherence bus channel.
// Several L1 ports share one core-level req/gnt/busy triplet. Ports are
// arbitrated round-robin, and ownership is locked for the whole transaction.
// A busy-hold watchdog raises a sticky flag when an owner holds busy too long.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   up_req         per-port bus request
//   up_busy        per-port transaction in progress
//   up_tx          per-port outgoing message, [NUM_PORTS-1:0][MSG_W-1:0]
//   up_gnt         per-port grant, one-hot or zero
//   dn_req         merged request to the bus arbiter
//   dn_gnt         grant from the bus arbiter
//   dn_busy        merged busy
//   dn_tx          merged message
//   owner_valid    a port currently owns the merger (REQ or OWN)
//   owner_id       index of the owning port
//   hold_err       sticky watchdog flag
//
// MSG_W defaults to the request-message width. The response-channel
// instance overrides it with the response-message width.
module l1_bus_merger #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MSG_W     = 32,
    parameter int unsigned HOLD_MAX  = 64,
    localparam int unsigned PW       = $clog2(NUM_PORTS),
    localparam int unsigned CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            up_req,
    input  logic [NUM_PORTS-1:0]            up_busy,
    input  logic [NUM_PORTS-1:0][MSG_W-1:0] up_tx,
    output logic [NUM_PORTS-1:0]            up_gnt,
    output logic                            dn_req,
    input  logic                            dn_gnt,
    output logic                            dn_busy,
    output logic [MSG_W-1:0]                dn_tx,
    output logic                            owner_valid,
    output logic [PW-1:0]                   owner_id,
    output logic                            hold_err
);

    typedef enum logic [1:0] {IDLE, REQ, OWN} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [PW-1:0] rr_ptr, rr_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt, hold_inc;
    logic          err_nxt;

    logic          found;
    logic [PW-1:0] pick;

    // Round-robin search upward from rr_ptr, with an explicit modulo wrap so
    // that non-power-of-2 port counts never select an out-of-range index.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_PORTS;
            if (!found && up_req[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign hold_inc = (hold_cnt == CW'(HOLD_MAX)) ? hold_cnt : hold_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;
        err_nxt   = hold_err;
        up_gnt    = '0;
        dn_req    = 1'b0;
        dn_busy   = 1'b0;
        dn_tx     = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                dn_req        = 1'b1;
                dn_tx         = up_tx[owner];
                up_gnt[owner] = dn_gnt;
                // A grant beats a same-cycle withdrawal.
                if (dn_gnt) begin
                    state_nxt = OWN;
                    rr_nxt    = PW'((32'(owner) + 1) % NUM_PORTS);
                    hold_nxt  = '0;
                end else if (!up_req[owner]) begin
                    state_nxt = IDLE;
                end
            end
            OWN: begin
                dn_busy  = up_busy[owner];
                dn_tx    = up_tx[owner];
                hold_nxt = hold_inc;
                // The flag is raised in the OWN cycle where the saturating
                // count reaches HOLD_MAX with busy still held.
                if (hold_inc == CW'(HOLD_MAX) && up_busy[owner]) begin
                    err_nxt = 1'b1;
                end
                if (!up_busy[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            hold_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
            hold_err <= err_nxt;
        end
    end

    assign owner_valid = (state != IDLE);
    assign owner_id    = owner_valid ? owner : '0;

endmodule

// File: tb/tb_l1_bus_merger.sv
// Directed bench for l1_bus_merger with 3 ports (non-power-of-2) and a short
// watchdog limit. Expected grant owners are queued when requests are driven
// and popped when the grant appears.
module tb_l1_bus_merger;

    localparam int unsigned NP = 3;
    localparam int unsigned MW = 16;
    localparam int unsigned HM = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NP-1:0]            up_req;
    logic [NP-1:0]            up_busy;
    logic [NP-1:0][MW-1:0]    up_tx;
    logic [NP-1:0]            up_gnt;
    logic                     dn_req;
    logic                     dn_gnt;
    logic                     dn_busy;
    logic [MW-1:0]            dn_tx;
    logic                     owner_valid;
    logic [1:0]               owner_id;
    logic                     hold_err;

    int n_cmp = 0;
    int n_bad = 0;
    int sb[$];

    l1_bus_merger #(.NUM_PORTS(NP), .MSG_W(MW), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst),
        .up_req(up_req), .up_busy(up_busy), .up_tx(up_tx), .up_gnt(up_gnt),
        .dn_req(dn_req), .dn_gnt(dn_gnt), .dn_busy(dn_busy), .dn_tx(dn_tx),
        .owner_valid(owner_valid), .owner_id(owner_id), .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_tx();
        for (int i = 0; i < int'(NP); i++) up_tx[i] = MW'($urandom);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        up_req  = '0;
        up_busy = '0;
        dn_gnt  = 1'b0;
        new_tx();
        tick();
        chk("rst_dn_req", 64'(dn_req), 64'd0);
        chk("rst_owner_valid", 64'(owner_valid), 64'd0);
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for dn_req, grants, checks the queued owner, then
    // holds the owner's busy for nbusy cycles and releases it.
    task automatic run_txn(input int nbusy);
        int w;
        logic [1:0] p;
        w = 0;
        while (dn_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("req_wait", 64'(dn_req), 64'd1);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        p = (sb.size() != 0) ? 2'(sb.pop_front()) : 2'd0;
        dn_gnt = 1'b1;
        #1;
        chk("gnt", 64'(up_gnt), 64'd1 << p);
        chk("owner_id", 64'(owner_id), 64'(p));
        chk("dn_tx_req", 64'(dn_tx), 64'(up_tx[p]));
        tick();
        dn_gnt     = 1'b0;
        up_busy[p] = 1'b1;
        for (int i = 0; i < nbusy; i++) begin
            new_tx();
            #1;
            chk("dn_busy", 64'(dn_busy), 64'd1);
            chk("dn_tx_own", 64'(dn_tx), 64'(up_tx[p]));
            chk("gnt_own", 64'(up_gnt), 64'd0);
            chk("dn_req_own", 64'(dn_req), 64'd0);
            tick();
        end
        up_busy[p] = 1'b0;
        #1;
        chk("busy_drop", 64'(dn_busy), 64'd0);
        chk("still_owned", 64'(owner_valid), 64'd1);
        tick();
        chk("idle_after", 64'(owner_valid), 64'd0);
        chk("idle_tx", 64'(dn_tx), 64'd0);
    endtask

    initial begin
        // Single port with explicit latencies
        do_reset();
        chk("reset_err", 64'(hold_err), 64'd0);
        chk("reset_tx", 64'(dn_tx), 64'd0);
        up_req[1] = 1'b1;
        sb.push_back(1);
        #1;
        chk("req_lat0", 64'(dn_req), 64'd0);
        tick();
        chk("req_lat1", 64'(dn_req), 64'd1);
        chk("req_owner", 64'(owner_id), 64'd1);
        chk("req_nogrant", 64'(up_gnt), 64'd0);
        tick();
        run_txn(3);
        up_req = '0;
        chk("single_err", 64'(hold_err), 64'd0);

        // Round-robin, all ports requesting
        do_reset();
        up_req = '1;
        for (int k = 0; k < 6; k++) sb.push_back(k % 3);
        for (int k = 0; k < 6; k++) run_txn(2);
        up_req = '0;
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Withdrawal before grant leaves rr_ptr alone
        do_reset();
        up_req = 3'b001;
        tick();
        chk("wd_req", 64'(dn_req), 64'd1);
        up_req = '0;
        #1;
        chk("wd_nogrant", 64'(up_gnt), 64'd0);
        tick();
        chk("wd_dn_req", 64'(dn_req), 64'd0);
        chk("wd_idle", 64'(owner_valid), 64'd0);
        up_req = 3'b011;
        sb.push_back(0);
        run_txn(2);
        up_req = '0;

        // Grant and withdrawal in the same cycle
        up_req = 3'b100;
        sb.push_back(2);
        tick();
        chk("sim_req", 64'(dn_req), 64'd1);
        dn_gnt = 1'b1;
        up_req = '0;
        #1;
        chk("sim_gnt", 64'(up_gnt), 64'd1 << 2'(sb.pop_front()));
        tick();
        dn_gnt     = 1'b0;
        up_busy[2] = 1'b1;
        #1;
        chk("sim_own", 64'(owner_valid), 64'd1);
        chk("sim_busy", 64'(dn_busy), 64'd1);
        chk("sim_id", 64'(owner_id), 64'd2);
        tick();
        up_busy = '0;
        tick();

        // Watchdog: busy held 10 OWN cycles with HOLD_MAX=4
        up_req = 3'b001;
        sb.push_back(0);
        tick();
        dn_gnt = 1'b1;
        #1;
        chk("wdg_gnt", 64'(up_gnt), 64'd1 << 2'(sb.pop_front()));
        up_req = '0;
        tick();
        dn_gnt     = 1'b0;
        up_busy[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (i == 2) chk("err_early", 64'(hold_err), 64'd0);
            chk("wdg_busy", 64'(dn_busy), 64'd1);
            tick();
        end
        chk("err_set", 64'(hold_err), 64'd1);
        up_busy = '0;
        tick();
        tick();
        tick();
        chk("err_sticky", 64'(hold_err), 64'd1);
        chk("wdg_idle", 64'(owner_valid), 64'd0);

        // Reset mid-OWN; rr_ptr must restart at 0
        up_req = 3'b010;
        sb.push_back(1);
        tick();
        dn_gnt = 1'b1;
        #1;
        chk("mid_gnt", 64'(up_gnt), 64'd1 << 2'(sb.pop_front()));
        up_req = '0;
        tick();
        dn_gnt     = 1'b0;
        up_busy[1] = 1'b1;
        #1;
        chk("mid_busy", 64'(dn_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(up_gnt), 64'd0);
        chk("mid_rst_req", 64'(dn_req), 64'd0);
        chk("mid_rst_busy", 64'(dn_busy), 64'd0);
        chk("mid_rst_tx", 64'(dn_tx), 64'd0);
        chk("mid_rst_valid", 64'(owner_valid), 64'd0);
        chk("mid_rst_id", 64'(owner_id), 64'd0);
        chk("mid_rst_err", 64'(hold_err), 64'd0);
        up_busy = '0;
        tick();
        rst    = 1'b0;
        up_req = 3'b110;
        tick();
        chk("post_rst_valid", 64'(owner_valid), 64'd1);
        chk("post_rst_id", 64'(owner_id), 64'd1);
        up_req = '0;
        tick();
        chk("post_rst_idle", 64'(owner_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
